// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with fractional baud generator.
// Words enter a FIFO over a valid/ready handshake and are serialised LSB
// first as start, DATA_BITS data bits, optional parity and STOP_BITS stop bits.
// Ports:
//   sys_clk_i    - system clock, rising edge
//   sys_rst_i    - synchronous active-high reset
//   tx_valid_i   - producer has a word on tx_data_i
//   tx_data_i    - word to send, LSB first
//   tx_ready_o   - FIFO not full; word taken when valid & ready
//   uart_tx      - serial line, idle high
//   uart_busy_o  - frame in progress or FIFO non-empty
//   fifo_level_o - words held in FIFO (excludes the word in the shifter)
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          tx_valid_i,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  output logic                          tx_ready_o,
  output logic                          uart_tx,
  output logic                          uart_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = 3;
  localparam logic [32:0] BAUD_INC = 33'(BAUD);
  localparam logic [32:0] CLK_LIM  = 33'(CLK_HZ);
  localparam bit          PAR_EN   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           acc_q, acc_d;
  logic [DATA_BITS-1:0]  word_q, word_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  uart_tx_q, uart_tx_d;
  logic                  busy_q, busy_d;
  logic [LW-1:0]         level_q, level_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  mem_d [FIFO_DEPTH];

  logic [32:0]           acc_sum_c;
  logic                  tick_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  empty_c;
  logic                  par_c;
  logic [IW-1:0]         idx_nxt_c;

  // Ready depends only on the registered level, so a pop cannot free a slot for a same-cycle push.
  assign tx_ready_o   = (level_q != LW'(FIFO_DEPTH));
  assign uart_tx      = uart_tx_q;
  assign uart_busy_o  = busy_q;
  assign fifo_level_o = level_q;

  assign acc_sum_c = {1'b0, acc_q} + BAUD_INC;
  assign tick_c    = (acc_sum_c >= CLK_LIM);
  assign push_c    = tx_valid_i && tx_ready_o;
  assign empty_c   = (level_q == '0);
  assign par_c     = (PARITY == 1) ? ~^word_q : ^word_q;
  assign idx_nxt_c = idx_q + IW'(1);

  // Next-state, baud accumulator, shifter and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    acc_d      = tick_c ? 32'(acc_sum_c - CLK_LIM) : 32'(acc_sum_c);
    word_d     = word_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    uart_tx_d  = uart_tx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    pop_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        uart_tx_d = 1'b1;
        if (!empty_c) pop_c = 1'b1;
      end
      S_START: begin
        if (tick_c) begin
          state_d   = S_DATA;
          idx_d     = '0;
          uart_tx_d = word_q[0];
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            if (PAR_EN) begin
              state_d   = S_PARITY;
              uart_tx_d = par_c;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              uart_tx_d  = 1'b1;
            end
          end else begin
            idx_d     = idx_nxt_c;
            uart_tx_d = word_q[idx_nxt_c];
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          uart_tx_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            if (!empty_c) pop_c = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        uart_tx_d = 1'b1;
      end
    endcase

    // Frame start: latch word, phase-align the baud generator, drive start bit.
    if (pop_c) begin
      word_d    = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
      acc_d     = '0;
      state_d   = S_START;
      uart_tx_d = 1'b0;
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = tx_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    level_d = level_q + LW'(push_c) - LW'(pop_c);
    busy_d  = (state_d != S_IDLE) || (level_d != '0);
  end

  // Control and line registers.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by level and pointers.
  always_ff @(posedge sys_clk_i) begin
    mem_q <= mem_d;
  end

endmodule
